// File: rtl/mult_controller.sv
// ----------------------------------------------------------------------------
// mult_controller
//   Moore-style control FSM for a shift-and-add multiplier. It sequences an
//   external datapath holding the multiplicand (A), the multiplier shift
//   register (B) and a double-width product register (P).
//
// Parameters
//   size   : multiplier operand width in bits (2..32)
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset
//   start  : begin a multiplication (only looked at while idle)
//   b_lsb  : current LSB of the B shift register
//   ldA    : load multiplicand register
//   ldB    : load multiplier shift register
//   clrP   : clear product register
//   ldP    : load P_hi + A into the product upper half
//   shP    : shift product right by one, carry in at the MSB
//   shB    : shift B right by one
//   busy   : high in every state except idle
//   done   : one-cycle completion pulse
// ----------------------------------------------------------------------------
module mult_controller #(
    parameter int unsigned size = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic b_lsb,
    output logic ldA,
    output logic ldB,
    output logic clrP,
    output logic ldP,
    output logic shP,
    output logic shB,
    output logic busy,
    output logic done
);

    localparam int unsigned CntW = $clog2(size + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(size - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StCheck = 3'd2,
        StAdd   = 3'd3,
        StShift = 3'd4,
        StDone  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = StIdle;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle:  state_d = start ? StLoad : StIdle;
            StLoad: begin
                cnt_d   = '0;
                state_d = StCheck;
            end
            StCheck: state_d = b_lsb ? StAdd : StShift;
            StAdd:   state_d = StShift;
            StShift: begin
                cnt_d   = cnt_q + 1'b1;
                // The last iteration is the one whose shift sees cnt == size-1
                state_d = (cnt_q == CntLast) ? StDone : StCheck;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from state only; unencoded states drive everything low
    always_comb begin
        ldA  = 1'b0;
        ldB  = 1'b0;
        clrP = 1'b0;
        ldP  = 1'b0;
        shP  = 1'b0;
        shB  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StIdle: ;
            StLoad: begin
                ldA  = 1'b1;
                ldB  = 1'b1;
                clrP = 1'b1;
                busy = 1'b1;
            end
            StCheck: busy = 1'b1;
            StAdd: begin
                ldP  = 1'b1;
                busy = 1'b1;
            end
            StShift: begin
                shP  = 1'b1;
                shB  = 1'b1;
                busy = 1'b1;
            end
            StDone: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_controller.sv
// ----------------------------------------------------------------------------
// tb_mult_controller
//   Directed bench for mult_controller (size = 8). A small behavioural
//   datapath (A, B, P registers) reacts to the controller's strobes so the
//   final product can be compared with hand-computed values.
// ----------------------------------------------------------------------------
module tb_mult_controller;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst, start, b_lsb;
    logic ldA, ldB, clrP, ldP, shP, shB, busy, done;

    int checks = 0;
    int errors = 0;

    // Datapath model
    logic [N-1:0]   a_in, b_in;
    logic [N-1:0]   a_q, b_q;
    logic [2*N-1:0] p_q;
    logic           c_q;

    always #5 clk = ~clk;

    mult_controller #(.size(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .b_lsb (b_lsb),
        .ldA   (ldA),
        .ldB   (ldB),
        .clrP  (clrP),
        .ldP   (ldP),
        .shP   (shP),
        .shB   (shB),
        .busy  (busy),
        .done  (done)
    );

    assign b_lsb = b_q[0];

    always @(posedge clk) begin
        if (ldA) a_q <= a_in;
        if (ldB) b_q <= b_in;
        if (shB) b_q <= b_q >> 1;
        if (clrP) begin
            p_q <= '0;
            c_q <= 1'b0;
        end
        if (ldP) {c_q, p_q[2*N-1:N]} <= {1'b0, p_q[2*N-1:N]} + {1'b0, a_q};
        if (shP) begin
            p_q <= {c_q, p_q[2*N-1:1]};
            c_q <= 1'b0;
        end
    end

    function automatic logic [7:0] outs();
        return {ldA, ldB, clrP, ldP, shP, shB, busy, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one multiplication from IDLE. Starts at a negedge, returns at the
    // negedge where done is high. poke pulses start mid-operation.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int exp_p, input int exp_cyc, input int exp_ldp,
                          input int exp_mask, input bit poke);
        int cyc, nldp, nsh, mask, excl;
        bit got_done;
        cyc = 0; nldp = 0; nsh = 0; mask = 0; excl = 0; got_done = 0;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " load"}, {29'd0, ldA, ldB, clrP}, 32'd7);
        for (int i = 0; i < 200; i++) begin
            if (busy) cyc++;
            if (poke && cyc == 5) start = 1'b1;
            if (poke && cyc == 6) start = 1'b0;
            if (((ldA | ldB | clrP) + ldP + (shP | shB) + done) > 1) excl++;
            if (ldP) begin
                nldp++;
                mask |= (1 << nsh);
            end
            if (shP) nsh++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done seen"}, {31'd0, got_done}, 32'd1);
        check({tag, " cycles"}, cyc, exp_cyc);
        check({tag, " ldP count"}, nldp, exp_ldp);
        check({tag, " ldP iters"}, mask, exp_mask);
        check({tag, " exclusive"}, excl, 0);
        check({tag, " product"}, {16'd0, p_q}, exp_p);
        start = 1'b0;
        @(negedge clk);
        check({tag, " idle after"}, {24'd0, outs()}, 32'd0);
    endtask

    initial begin
        int gap;
        bit seen;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("reset idle", {24'd0, outs()}, 32'd0);
            @(negedge clk);
        end

        // 2 + 2*size + popcount(B)
        run_op("b00", 8'hFF, 8'h00, 0,      18, 0, 0,        1'b0);
        run_op("ffff", 8'hFF, 8'hFF, 'hFE01, 26, 8, 'hFF,    1'b0);
        run_op("13x10", 8'd13, 8'h0A, 130,  20, 2, 'b1010,   1'b0);
        run_op("poke", 8'd7, 8'h00, 0,      18, 0, 0,        1'b1);

        // Abort during iteration 4
        a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap = 0;
        for (int i = 0; i < 100 && gap < 4; i++) begin
            @(negedge clk);
            if (shP) gap++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort idle", {24'd0, outs()}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done | busy) seen = 1'b1;
        end
        check("abort no done", {31'd0, seen}, 32'd0);
        run_op("3x5", 8'd3, 8'd5, 15, 20, 2, 'b101, 1'b0);

        // start held high: one IDLE cycle between operations
        a_in = 8'd1; b_in = 8'h00; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b first done", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("b2b idle gap", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b reload", {29'd0, ldA, ldB, clrP}, 32'd7);
        gap = 2;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            gap++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b second done", {31'd0, seen}, 32'd1);
        check("b2b done spacing", gap, 19);
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_controller.md
MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 The module SHALL have parameter size, default 8, giving the multiplier operand width in bits; legal range is 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a multiplication; sampled only in IDLE.
REQ-005 The module SHALL have port b_lsb, input, 1 bit: current LSB of the multiplier (B) shift register.
REQ-006 The module SHALL have port ldA, output, 1 bit: load the multiplicand register.
REQ-007 The module SHALL have port ldB, output, 1 bit: load the multiplier shift register.
REQ-008 The module SHALL have port clrP, output, 1 bit: clear the product register.
REQ-009 The module SHALL have port ldP, output, 1 bit: load the adder result (P_hi + A) into the product upper half.
REQ-010 The module SHALL have port shP, output, 1 bit: shift the product register right by one, carry in at the MSB.
REQ-011 The module SHALL have port shB, output, 1 bit: shift the B register right by one.
REQ-012 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The module SHALL implement a Moore FSM with states IDLE, LOAD, CHECK, ADD, SHIFT and DONE; outputs decode from state only.
REQ-015 The module SHALL hold an iteration counter cnt of width clog2(size+1).
REQ-016 IDLE: all control outputs 0; start=1 -> LOAD; otherwise remain in IDLE.
REQ-017 LOAD: ldA=ldB=clrP=1 for exactly one cycle; cnt <= 0; unconditional -> CHECK.
REQ-018 CHECK: no control outputs asserted; b_lsb=1 -> ADD; b_lsb=0 -> SHIFT.
REQ-019 ADD: ldP=1 for exactly one cycle; unconditional -> SHIFT.
REQ-020 SHIFT: shP=shB=1 for one cycle; cnt <= cnt+1; cnt==size-1 -> DONE, otherwise -> CHECK.
REQ-021 DONE: done=1 for exactly one cycle; unconditional -> IDLE.
REQ-022 start SHALL be ignored in every state other than IDLE; no queuing.
REQ-023 Cycles from LOAD to DONE inclusive SHALL be 2 + 2*size + popcount(B), measured from the first cycle after start was sampled in IDLE.
REQ-024 With start held high continuously, the module SHALL return to IDLE after DONE and enter LOAD on the following cycle; back-to-back operations are separated by exactly one IDLE cycle.
REQ-025 At most one of {ldA/ldB/clrP group, ldP, shP/shB group, done} SHALL be active in any cycle.
REQ-026 Any unencoded state SHALL transition to IDLE on the next edge with all outputs 0.

Reset
REQ-027 rst=1 at a rising edge SHALL force state=IDLE and cnt=0, overriding start and all other inputs.
REQ-028 After reset, ldA, ldB, clrP, ldP, shP, shB, busy and done SHALL all be 0.
REQ-029 rst asserted in any non-IDLE state SHALL abort the operation without producing a done pulse; the next start SHALL run a full, fresh sequence.

Verification
REQ-030 Reset then idle: rst high 2 cycles, start=0 -> all outputs 0, busy=0 for 10 cycles.
REQ-031 size=8, B=0x00 (b_lsb driven from bench B model): start pulse -> LOAD, 8x(CHECK,SHIFT), no ldP, done on cycle 18 after LOAD start; product 0.
REQ-032 size=8, A=0xFF, B=0xFF -> 8 ldP pulses, done on cycle 26; datapath product 0xFE01.
REQ-033 size=8, A=13, B=0x0A -> ldP exactly on iterations 1 and 3 (0-based), done on cycle 20; product 130.
REQ-034 rst asserted during iteration 4 -> next cycle IDLE, busy=0, no done; a subsequent start with A=3, B=5 yields product 15.
REQ-035 start held high throughout two operations -> done pulses separated by exactly one IDLE cycle; start pulses during busy are ignored.
